clock_div_bank: RTL and testbench

Parametrised successor to the system clock block. It generates NUM_CH independently programmable divided clocks from one system clock. Each channel provides a 50%-duty output, a one-cycle tick strobe, glitch-free enable/disable, and shadowed divisor reload at period boundaries. It sits between the system clock source and the peripheral/watchdog/low-speed clock consumers.

---
 rtl/clock_div_bank_pkg.sv | 22 ++
 rtl/clock_div_bank_if.sv | 36 +++
 rtl/clock_div_bank_ch.sv | 113 +++++++++++
 rtl/clock_div_bank.sv | 55 +++++
 tb/tb_clock_div_bank.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_div_bank_pkg.sv
// ============================================================================
// Module : clock_pkg
// Brief  : Shared types and defaults for the clock divider bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

  localparam int DIV_W_DEF   = 16;
  localparam int DEF_DIV_DEF = 1;
  localparam int SEL_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/clock_div_bank_if.sv
// ============================================================================
// Module : clock_div_bank_if
// Brief  : Control and status bundle of the clock divider bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_div_bank_if
  import clock_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DIV_W_DEF
);

  logic [NUM_CH-1:0] ch_enable;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [DIV_W-1:0]  div_data;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] ch_active;
  logic [NUM_CH-1:0] div_pending;

  modport master (
    output ch_enable, div_wr, div_sel, div_data,
    input  clk_out, tick, ch_active, div_pending
  );

  modport slave (
    input  ch_enable, div_wr, div_sel, div_data,
    output clk_out, tick, ch_active, div_pending
  );

endinterface

`default_nettype wire

// File: rtl/clock_div_bank_ch.sv
// ============================================================================
// Module : clock_div_ch
// Brief  : One divider channel: counter, run/drain FSM, shadowed divisor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_div_ch
  import clock_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ch_enable,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_data,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_ch_active,
  output logic             o_div_pending
);

  localparam logic [DIV_W-1:0] c_def_div = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] c_one     = {{(DIV_W-1){1'b0}}, 1'b1};

  ch_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;
  logic             w_term;
  logic             w_rise;
  logic             w_apply;

  assign w_term = (cnt_q == active_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    w_rise    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (i_ch_enable) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (!i_ch_enable && !clk_out_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          if (w_term) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            w_rise    = ~clk_out_q;
          end else begin
            cnt_d = cnt_q + c_one;
          end
          // A disabled channel keeps counting until its high phase ends.
          if (!i_ch_enable) state_d = w_term ? ST_IDLE : ST_DRAIN;
          else              state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase

    // Idle channels track the shadow directly; running ones only on a rise.
    w_apply = (state_q == ST_IDLE) || w_rise;
    if (w_apply) active_d = shadow_q;
    if (i_wr)    shadow_d = i_wr_data;
    tick_d    = w_rise;
    pending_d = (state_d != ST_IDLE) && (i_wr || (pending_q && !w_apply));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      active_q  <= c_def_div;
      shadow_q  <= c_def_div;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign o_clk_out     = clk_out_q;
  assign o_tick        = tick_q;
  assign o_ch_active   = (state_q != ST_IDLE);
  assign o_div_pending = pending_q;

endmodule

`default_nettype wire

// File: rtl/clock_div_bank.sv
// ============================================================================
// Module : clock_div_bank
// Brief  : NUM_CH independent programmable clock dividers with write fan-out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_div_bank
  import clock_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  clock_div_bank_if.slave      bus
);

  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_clk_out;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_ch_active;
  logic [NUM_CH-1:0] w_div_pending;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Indices at or above NUM_CH match no channel and are dropped.
      assign w_wr[i] = bus.div_wr && (bus.div_sel == SEL_W'(i));

      clock_div_ch #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
      ) u_ch (
        .clk           (clk),
        .rst_n         (reset),
        .i_ch_enable   (bus.ch_enable[i]),
        .i_wr          (w_wr[i]),
        .i_wr_data     (bus.div_data),
        .o_clk_out     (w_clk_out[i]),
        .o_tick        (w_tick[i]),
        .o_ch_active   (w_ch_active[i]),
        .o_div_pending (w_div_pending[i])
      );
    end
  endgenerate

  assign bus.clk_out     = w_clk_out;
  assign bus.tick        = w_tick;
  assign bus.ch_active   = w_ch_active;
  assign bus.div_pending = w_div_pending;

endmodule

`default_nettype wire

// File: tb/tb_clock_div_bank.sv
// ============================================================================
// Module : tb_clock_div_bank
// Brief  : Self-checking bench for clock_div_bank with a per-cycle scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_div_bank;

  typedef struct packed {
    logic [3:0] co;
    logic [3:0] tk;
    logic [3:0] act;
    logic [3:0] pd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  clock_div_bank_if #(.NUM_CH(4), .DIV_W(16)) bus ();

  clock_div_bank #(
    .NUM_CH  (4),
    .DIV_W   (16),
    .DEF_DIV (1)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push n identical expected cycles; channels outside the mask expect idle.
  task automatic push(input logic [3:0] m, input logic co, input logic tk,
                      input logic act, input logic pd, input int n);
    exp_t e;
    e.co  = co  ? m : 4'h0;
    e.tk  = tk  ? m : 4'h0;
    e.act = act ? m : 4'h0;
    e.pd  = pd  ? m : 4'h0;
    for (int k = 0; k < n; k++) sb_q.push_back(e);
  endtask

  task automatic run_check(input string name, input int n);
    exp_t e;
    exp_t o;
    for (int k = 0; k < n; k++) begin
      step();
      o = {bus.clk_out, bus.tick, bus.ch_active, bus.div_pending};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s cyc %0d: scoreboard empty, got %h", name, k, o);
      end else begin
        e = sb_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s cyc %0d: got co/tk/act/pd=%h required %h", name, k, o, e);
        end
      end
    end
  endtask

  task automatic write_div(input string name, input logic [2:0] sel,
                           input logic [15:0] data);
    bus.div_wr   = 1'b1;
    bus.div_sel  = sel;
    bus.div_data = data;
    run_check(name, 1);
    bus.div_wr   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.clk_out, bus.tick, bus.ch_active, bus.div_pending} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0000",
               {bus.clk_out, bus.tick, bus.ch_active, bus.div_pending});
    end
    rst_n = 1'b1;
    push(4'h0, 0, 0, 0, 0, 2);
    run_check("reset_idle", 2);
  endtask

  task automatic test_default_div();
    bus.ch_enable = 4'b0001;
    for (int p = 0; p < 3; p++) begin
      push(4'b0001, 0, 0, 1, 0, 2);
      push(4'b0001, 1, 1, 1, 0, 1);
      push(4'b0001, 1, 0, 1, 0, 1);
    end
    run_check("def_div_ch0", 12);
    bus.ch_enable = 4'b0000;
    push(4'h0, 0, 0, 0, 0, 2);
    run_check("def_div_stop", 2);
  endtask

  task automatic test_div_zero();
    push(4'h0, 0, 0, 0, 0, 1);
    write_div("div0_wr", 3'd1, 16'd0);
    bus.ch_enable = 4'b0010;
    push(4'b0010, 0, 0, 1, 0, 1);
    for (int p = 0; p < 4; p++) begin
      push(4'b0010, 1, 1, 1, 0, 1);
      if (p < 3) push(4'b0010, 0, 0, 1, 0, 1);
    end
    run_check("div0_ch1", 8);
    bus.ch_enable = 4'b0000;
    push(4'h0, 0, 0, 0, 0, 2);
    run_check("div0_stop", 2);
  endtask

  task automatic test_reload();
    push(4'h0, 0, 0, 0, 0, 1);
    write_div("reload_wr3", 3'd2, 16'd3);
    bus.ch_enable = 4'b0100;
    push(4'b0100, 0, 0, 1, 0, 4);
    push(4'b0100, 1, 1, 1, 0, 1);
    push(4'b0100, 1, 0, 1, 0, 1);
    run_check("reload_div3", 6);
    push(4'b0100, 1, 0, 1, 1, 1);
    write_div("reload_wr7", 3'd2, 16'd7);
    push(4'b0100, 1, 0, 1, 1, 1);
    push(4'b0100, 0, 0, 1, 1, 4);
    push(4'b0100, 1, 1, 1, 0, 1);
    push(4'b0100, 1, 0, 1, 0, 7);
    push(4'b0100, 0, 0, 1, 0, 8);
    run_check("reload_div7", 21);
    bus.ch_enable = 4'b0000;
    push(4'h0, 0, 0, 0, 0, 2);
    run_check("reload_stop", 2);
  endtask

  task automatic test_drain();
    push(4'h0, 0, 0, 0, 0, 1);
    write_div("drain_wr4", 3'd0, 16'd4);
    bus.ch_enable = 4'b0001;
    push(4'b0001, 0, 0, 1, 0, 5);
    push(4'b0001, 1, 1, 1, 0, 1);
    run_check("drain_run", 6);
    bus.ch_enable = 4'b0000;
    push(4'b0001, 1, 0, 1, 0, 4);
    push(4'h0, 0, 0, 0, 0, 6);
    run_check("drain_full_high", 10);
  endtask

  task automatic test_redrain();
    bus.ch_enable = 4'b0001;
    push(4'b0001, 0, 0, 1, 0, 5);
    push(4'b0001, 1, 1, 1, 0, 1);
    run_check("redrain_run", 6);
    bus.ch_enable = 4'b0000;
    push(4'b0001, 1, 0, 1, 0, 1);
    run_check("redrain_drain", 1);
    bus.ch_enable = 4'b0001;
    push(4'b0001, 1, 0, 1, 0, 3);
    push(4'b0001, 0, 0, 1, 0, 5);
    push(4'b0001, 1, 1, 1, 0, 1);
    run_check("redrain_resume", 9);
    bus.ch_enable = 4'b0000;
    push(4'b0001, 1, 0, 1, 0, 4);
    push(4'h0, 0, 0, 0, 0, 2);
    run_check("redrain_stop", 6);
  endtask

  task automatic test_bad_sel();
    bus.ch_enable = 4'b0001;
    push(4'b0001, 0, 0, 1, 0, 2);
    run_check("badsel_pre", 2);
    push(4'b0001, 0, 0, 1, 0, 1);
    write_div("badsel_wr", 3'd5, 16'd0);
    push(4'b0001, 0, 0, 1, 0, 2);
    push(4'b0001, 1, 1, 1, 0, 1);
    push(4'b0001, 1, 0, 1, 0, 4);
    push(4'b0001, 0, 0, 1, 0, 5);
    run_check("badsel_timing", 12);
    bus.ch_enable = 4'b0000;
    push(4'h0, 0, 0, 0, 0, 2);
    run_check("badsel_stop", 2);
  endtask

  task automatic test_reset_mid();
    push(4'h0, 0, 0, 0, 0, 3);
    write_div("rstmid_wr2", 3'd2, 16'd7);
    write_div("rstmid_wr3", 3'd3, 16'd2);
    write_div("rstmid_wr1", 3'd1, 16'd0);
    bus.ch_enable = 4'b1111;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.clk_out !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_clk_out: got %h required 0", bus.clk_out);
    end
    checks++;
    if (bus.tick !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_tick: got %h required 0", bus.tick);
    end
    checks++;
    if (bus.ch_active !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_active: got %h required 0", bus.ch_active);
    end
    checks++;
    if (bus.div_pending !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_pending: got %h required 0", bus.div_pending);
    end
    step();
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      push(4'b1111, 0, 0, 1, 0, 2);
      push(4'b1111, 1, 1, 1, 0, 1);
      push(4'b1111, 1, 0, 1, 0, 1);
    end
    run_check("rstmid_restart", 8);
    bus.ch_enable = 4'b0000;
    push(4'h0, 0, 0, 0, 0, 2);
    run_check("rstmid_stop", 2);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.ch_enable = 4'b0000;
    bus.div_wr    = 1'b0;
    bus.div_sel   = 3'd0;
    bus.div_data  = 16'd0;
    test_reset();
    test_default_div();
    test_div_zero();
    test_reload();
    test_drain();
    test_redrain();
    test_bad_sel();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
